tdm_demux2: RTL and testbench

Receive-side counterpart of the lab 2:1 select/mux path. The mux side interleaves two channels, X and Y, onto one serial line, one bit per slot, with the select line alternating each slot. This block de-interleaves that bit stream back into two parallel WIDTH-bit words and pulses a strobe when a complete frame has been reconstructed. It sits between the serial line and the board outputs (LEDR / HEX drivers).

---
 rtl/tdm_demux2_pkg.sv | 17 +
 rtl/tdm_demux2_sipo_shift.sv | 36 +++
 rtl/tdm_demux2.sv | 151 +++++++++++++++
 tb/tb_tdm_demux2.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux2_pkg.sv
// Shared types and constants for the two-channel TDM de-interleaver.
package tdm_demux2_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned WIDTH_DEFAULT = 4;
    localparam int unsigned FRAME_SLOTS   = 2 * WIDTH_DEFAULT;

    // A frame carries one X and one Y word interleaved slot by slot.
    function automatic int unsigned frame_slots(input int unsigned width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/tdm_demux2_sipo_shift.sv
// LSB-first serial-in/parallel-out register; word_d_o exposes the value the
// register will hold after this edge, so a completing bit can be captured directly.
module sipo_shift #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] word_d_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Next shift-register contents: new bit enters at the MSB end.
    always_comb begin
        if (en) begin
            sr_d = {din, sr_q[WIDTH-1:1]};
        end else begin
            sr_d = sr_q;
        end
    end

    // Shift-register storage.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sr_q <= {WIDTH{1'b0}};
        end else begin
            sr_q <= sr_d;
        end
    end

    assign word_d_o = sr_d;

endmodule

// File: rtl/tdm_demux2.sv
// De-interleaves an alternating X/Y serial slot stream into two parallel words,
// with frame lock tracking and framing-error detection.
module tdm_demux2
    import tdm_demux2_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] x_word,
    output logic [WIDTH-1:0] y_word,
    output logic             word_valid,
    output logic             slot_sel,
    output logic             locked,
    output logic             frame_err
);

    localparam int unsigned FSLOTS = frame_slots(WIDTH);
    localparam int unsigned CW     = $clog2(FSLOTS);
    localparam logic [CW-1:0] LAST_SLOT = CW'(FSLOTS - 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] x_word_q, x_word_d;
    logic [WIDTH-1:0] y_word_q, y_word_d;
    logic             word_valid_q, word_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             x_en_s, y_en_s;
    logic [WIDTH-1:0] x_next_s, y_next_s;

    // Decide which channel register (if any) accepts this cycle's bit.
    always_comb begin
        x_en_s = 1'b0;
        y_en_s = 1'b0;
        if (din_valid) begin
            case (state_q)
                ST_IDLE: begin
                    x_en_s = sync;
                end
                ST_RUN: begin
                    if (sync) begin
                        x_en_s = 1'b1;
                    end else if (cnt_q != CNT_ZERO) begin
                        x_en_s = ~cnt_q[0];
                        y_en_s = cnt_q[0];
                    end else begin
                        x_en_s = 1'b0;
                    end
                end
                default: begin
                    x_en_s = 1'b0;
                end
            endcase
        end else begin
            x_en_s = 1'b0;
        end
    end

    sipo_shift #(.WIDTH(WIDTH)) u_x_shift (
        .clock    (clock),
        .resetn   (resetn),
        .en       (x_en_s),
        .din      (din),
        .word_d_o (x_next_s)
    );

    sipo_shift #(.WIDTH(WIDTH)) u_y_shift (
        .clock    (clock),
        .resetn   (resetn),
        .en       (y_en_s),
        .din      (din),
        .word_d_o (y_next_s)
    );

    // Frame FSM, slot counter and output word updates; sync outranks completion.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        x_word_d     = x_word_q;
        y_word_d     = y_word_q;
        word_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (din_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (sync) begin
                        cnt_d   = CNT_ONE;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (sync) begin
                        cnt_d       = CNT_ONE;
                        frame_err_d = (cnt_q != CNT_ZERO);
                    end else if (cnt_q == CNT_ZERO) begin
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                        cnt_d       = CNT_ZERO;
                    end else if (cnt_q == LAST_SLOT) begin
                        cnt_d        = CNT_ZERO;
                        word_valid_d = 1'b1;
                        x_word_d     = x_next_s;
                        y_word_d     = y_next_s;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= CNT_ZERO;
            x_word_q     <= {WIDTH{1'b0}};
            y_word_q     <= {WIDTH{1'b0}};
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            x_word_q     <= x_word_d;
            y_word_q     <= y_word_d;
            word_valid_q <= word_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign x_word     = x_word_q;
    assign y_word     = y_word_q;
    assign word_valid = word_valid_q;
    assign frame_err  = frame_err_q;
    assign slot_sel   = cnt_q[0];
    assign locked     = (state_q == ST_RUN);

endmodule

// File: tb/tb_tdm_demux2.sv
// Self-checking bench for tdm_demux2 (WIDTH=4): vector table, directed corner
// sequences and random traffic against a frame-level reference model.
module tb_tdm_demux2;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       sync = 1'b0;
    logic [3:0] x_word, y_word;
    logic       word_valid, slot_sel, locked, frame_err;

    int total = 0;
    int bad = 0;

    tdm_demux2 #(.WIDTH(4)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .din        (din),
        .din_valid  (din_valid),
        .sync       (sync),
        .x_word     (x_word),
        .y_word     (y_word),
        .word_valid (word_valid),
        .slot_sel   (slot_sel),
        .locked     (locked),
        .frame_err  (frame_err)
    );

    always #5 clock = ~clock;

    // Reference model: list of bits collected for the current frame.
    bit       m_lock;
    int       m_pos;
    bit       m_bits[8];
    bit [3:0] m_x, m_y;
    bit       m_wv, m_fe;
    int       n_wv, n_fe;

    task automatic model_reset();
        m_lock = 1'b0; m_pos = 0; m_x = 4'h0; m_y = 4'h0;
        m_wv = 1'b0; m_fe = 1'b0;
    endtask

    task automatic model_clk(input bit d, input bit v, input bit s);
        m_wv = 1'b0;
        m_fe = 1'b0;
        if (v) begin
            if (!m_lock) begin
                if (s) begin
                    m_lock = 1'b1; m_bits[0] = d; m_pos = 1;
                end
            end else if (s) begin
                if (m_pos != 0) m_fe = 1'b1;
                m_bits[0] = d; m_pos = 1;
            end else if (m_pos == 0) begin
                m_fe = 1'b1; m_lock = 1'b0;
            end else begin
                m_bits[m_pos] = d;
                m_pos = m_pos + 1;
                if (m_pos == 8) begin
                    m_x = 4'h0; m_y = 4'h0;
                    for (int k = 0; k < 4; k++) begin
                        m_x = m_x + (4'(m_bits[2*k]) << k);
                        m_y = m_y + (4'(m_bits[2*k+1]) << k);
                    end
                    m_wv = 1'b1;
                    m_pos = 0;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("x_word", 32'(x_word), 32'(m_x));
        chk("y_word", 32'(y_word), 32'(m_y));
        chk("word_valid", 32'(word_valid), 32'(m_wv));
        chk("frame_err", 32'(frame_err), 32'(m_fe));
        chk("locked", 32'(locked), 32'(m_lock));
        chk("slot_sel", 32'(slot_sel), 32'(m_pos % 2));
    endtask

    task automatic step(input bit d, input bit v, input bit s);
        din = d; din_valid = v; sync = s;
        @(posedge clock);
        model_clk(d, v, s);
        #1;
        chk_model();
        if (word_valid === 1'b1) n_wv++;
        if (frame_err === 1'b1) n_fe++;
    endtask

    task automatic send_frame(input bit [3:0] x, input bit [3:0] y);
        for (int s = 0; s < 8; s++) begin
            step((s % 2 == 0) ? x[s/2] : y[s/2], 1'b1, s == 0);
        end
    endtask

    typedef struct {
        bit       d, v, s;
        bit [3:0] ex, ey;
        bit       ewv, efe, elk, esel;
    } vec_t;

    vec_t vt[10];

    initial begin
        // Single frame 1,0,0,0,1,1,0,1 with one stall (sync during the stall is ignored).
        vt[0] = '{1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[1] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[2] = '{1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[3] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[4] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[5] = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[6] = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[7] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[8] = '{1'b1, 1'b1, 1'b0, 4'h5, 4'hC, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[9] = '{1'b0, 1'b0, 1'b0, 4'h5, 4'hC, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset held for 3 cycles.
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_x", 32'(x_word), 32'h0);
        chk("rst_y", 32'(y_word), 32'h0);
        chk("rst_wv", 32'(word_valid), 32'h0);
        chk("rst_fe", 32'(frame_err), 32'h0);
        chk("rst_lock", 32'(locked), 32'h0);
        chk("rst_sel", 32'(slot_sel), 32'h0);
        @(negedge clock);
        resetn = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        chk("idle_discard_lock", 32'(locked), 32'h0);

        // Table vectors.
        for (int i = 0; i < 10; i++) begin
            step(vt[i].d, vt[i].v, vt[i].s);
            chk($sformatf("vec%0d_x", i), 32'(x_word), 32'(vt[i].ex));
            chk($sformatf("vec%0d_y", i), 32'(y_word), 32'(vt[i].ey));
            chk($sformatf("vec%0d_wv", i), 32'(word_valid), 32'(vt[i].ewv));
            chk($sformatf("vec%0d_fe", i), 32'(frame_err), 32'(vt[i].efe));
            chk($sformatf("vec%0d_lock", i), 32'(locked), 32'(vt[i].elk));
            chk($sformatf("vec%0d_sel", i), 32'(slot_sel), 32'(vt[i].esel));
        end

        // Stall tolerance: same frame with 1-3 idle cycles between every bit.
        begin
            bit [7:0] st;
            int sel_seen;
            st = 8'b1011_0001;
            for (int s = 0; s < 8; s++) begin
                step(st[s], 1'b1, s == 0);
                sel_seen = int'(slot_sel);
                for (int g = 0; g < 1 + (s % 3); g++) begin
                    step(1'b1, 1'b0, 1'b1);
                    chk("stall_sel_hold", 32'(slot_sel), 32'(sel_seen));
                end
            end
            chk("stall_x", 32'(x_word), 32'h5);
            chk("stall_y", 32'(y_word), 32'hC);
        end

        // Back-to-back frames.
        n_wv = 0; n_fe = 0;
        send_frame(4'hF, 4'h0);
        chk("b2b_wv1", 32'(word_valid), 32'h1);
        chk("b2b_x1", 32'(x_word), 32'hF);
        chk("b2b_y1", 32'(y_word), 32'h0);
        send_frame(4'h3, 4'hA);
        chk("b2b_wv2", 32'(word_valid), 32'h1);
        chk("b2b_x2", 32'(x_word), 32'h3);
        chk("b2b_y2", 32'(y_word), 32'hA);
        chk("b2b_strobes", 32'(n_wv), 32'd2);
        chk("b2b_errs", 32'(n_fe), 32'd0);

        // Early sync at slot 5, then X=9,Y=6.
        n_wv = 0; n_fe = 0;
        for (int s = 0; s < 5; s++) step(1'b1, 1'b1, s == 0);
        step(1'b1, 1'b1, 1'b1);
        chk("early_fe", 32'(frame_err), 32'h1);
        chk("early_x_hold", 32'(x_word), 32'h3);
        chk("early_y_hold", 32'(y_word), 32'hA);
        for (int s = 1; s < 8; s++) step((s % 2 == 0) ? 1'(4'h9 >> (s/2)) : 1'(4'h6 >> (s/2)), 1'b1, 1'b0);
        chk("early_x", 32'(x_word), 32'h9);
        chk("early_y", 32'(y_word), 32'h6);
        chk("early_fe_count", 32'(n_fe), 32'd1);
        chk("early_wv_count", 32'(n_wv), 32'd1);

        // Early sync on the last slot is an error, not a completion.
        n_wv = 0; n_fe = 0;
        for (int s = 0; s < 7; s++) step(1'b0, 1'b1, s == 0);
        step(1'b0, 1'b1, 1'b1);
        chk("last_sync_wv", 32'(n_wv), 32'd0);
        chk("last_sync_fe", 32'(n_fe), 32'd1);
        for (int s = 1; s < 8; s++) step(1'b0, 1'b1, 1'b0);

        // Missing sync at slot 0, then reset mid-frame.
        step(1'b1, 1'b1, 1'b0);
        chk("nosync_fe", 32'(frame_err), 32'h1);
        chk("nosync_lock", 32'(locked), 32'h0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        chk("midrst_x", 32'(x_word), 32'h0);
        chk("midrst_y", 32'(y_word), 32'h0);
        chk("midrst_lock", 32'(locked), 32'h0);
        chk("midrst_sel", 32'(slot_sel), 32'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        n_wv = 0;
        for (int s = 0; s < 10; s++) step(1'b1, 1'b1, 1'b0);
        chk("postrst_no_wv", 32'(n_wv), 32'd0);

        // Random traffic: mostly well-formed frames with stalls and stray syncs.
        for (int i = 0; i < 1500; i++) begin
            bit v, s;
            v = ($urandom_range(3) != 0);
            if (m_pos == 0) s = ($urandom_range(9) != 0);
            else s = ($urandom_range(15) == 0);
            step(1'(($urandom() & 32'h1) != 32'h0), v, s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
